// File: rtl/inert_rd_sequencer_pkg.sv
// Shared types and constants for the inertial sensor read sequencer:
// FSM state encoding, sensor register map and the fixed SPI command tables.
package inert_rd_sequencer_pkg;

  typedef enum logic [2:0] {
    INIT_WAIT,
    CFG,
    CFG_WT,
    WAIT_INT,
    RD,
    RD_WT,
    PUB
  } state_e;

  localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_CTRL1_XL = 7'h10;
  localparam logic [6:0] ADDR_CTRL2_G  = 7'h11;
  localparam logic [6:0] ADDR_CTRL5_C  = 7'h14;
  localparam logic [6:0] ADDR_PTCH_L   = 7'h24;
  localparam logic [6:0] ADDR_PTCH_H   = 7'h25;
  localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H     = 7'h2D;

  function automatic logic [15:0] spi_cmd(input logic rw, input logic [6:0] addr,
                                          input logic [7:0] data);
    return {rw, addr, data};
  endfunction

  // Data-ready interrupt, accel ODR/range, gyro ODR/range, register rounding
  localparam logic [15:0] CFG_CMD [4] = '{
    spi_cmd(1'b0, ADDR_INT_CTRL, 8'h02),
    spi_cmd(1'b0, ADDR_CTRL1_XL, 8'h53),
    spi_cmd(1'b0, ADDR_CTRL2_G,  8'h50),
    spi_cmd(1'b0, ADDR_CTRL5_C,  8'h60)
  };

  localparam logic [15:0] RD_CMD [4] = '{
    spi_cmd(1'b1, ADDR_PTCH_L, 8'h00),
    spi_cmd(1'b1, ADDR_PTCH_H, 8'h00),
    spi_cmd(1'b1, ADDR_AZ_L,   8'h00),
    spi_cmd(1'b1, ADDR_AZ_H,   8'h00)
  };

endpackage

// File: rtl/inert_rd_sequencer_if.sv
// Request/response handshake between the sequencer and the SPI master.
interface inert_rd_sequencer_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_rd_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/inert_rd_sequencer.sv
// Powers up and configures the inertial sensor, then on each data-ready reads
// pitch rate and Z acceleration byte by byte and publishes them as one coherent pair.
module inert_rd_sequencer
  import inert_rd_sequencer_pkg::*;
#(
  parameter int TMR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 INT,
  inert_rd_sequencer_if.master spi,
  output logic                 vld,
  output logic signed [15:0]   ptch_rt,
  output logic signed [15:0]   AZ
);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0][7:0]    byte_q, byte_d;
  logic               wrt_q, wrt_d;
  logic [15:0]        cmd_q, cmd_d;
  logic               vld_q, vld_d;
  logic signed [15:0] ptch_q, ptch_d;
  logic signed [15:0] az_q, az_d;
  logic               int_s;
  logic               unused_rd_hi;

  sync_2ff u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (INT),
    .q     (int_s)
  );

  assign unused_rd_hi = ^spi.rd_data[15:8];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    vld_d   = 1'b0;
    ptch_d  = ptch_q;
    az_d    = az_q;

    case (state_q)
      INIT_WAIT: begin
        // Timer stops at terminal count and is only re-armed by reset
        if (timer_q == {TMR_W{1'b1}}) begin
          state_d = CFG;
          idx_d   = 2'd0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      CFG: begin
        wrt_d   = 1'b1;
        cmd_d   = CFG_CMD[idx_q];
        state_d = CFG_WT;
      end
      CFG_WT: begin
        if (spi.done) begin
          if (idx_q == 2'd3) begin
            state_d = WAIT_INT;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = CFG;
          end
        end
      end
      WAIT_INT: begin
        if (int_s) begin
          idx_d   = 2'd0;
          state_d = RD;
        end
      end
      RD: begin
        wrt_d   = 1'b1;
        cmd_d   = RD_CMD[idx_q];
        state_d = RD_WT;
      end
      RD_WT: begin
        if (spi.done) begin
          byte_d[idx_q] = spi.rd_data[7:0];
          if (idx_q == 2'd3) begin
            // Publish on the edge that takes the last byte so vld lands one clk
            // after the final done; AZ_H is bypassed straight from rd_data.
            ptch_d  = {byte_q[1], byte_q[0]};
            az_d    = {spi.rd_data[7:0], byte_q[2]};
            vld_d   = 1'b1;
            state_d = PUB;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = RD;
          end
        end
      end
      PUB: begin
        state_d = WAIT_INT;
      end
      default: begin
        state_d = INIT_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_WAIT;
      timer_q <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
      ptch_q  <= '0;
      az_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      vld_q   <= vld_d;
      ptch_q  <= ptch_d;
      az_q    <= az_d;
    end
  end

  assign spi.wrt = wrt_q;
  assign spi.cmd = cmd_q;
  assign vld     = vld_q;
  assign ptch_rt = ptch_q;
  assign AZ      = az_q;

endmodule
